// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package mips_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP
  } fetch_state_e;

endpackage

// File: rtl/mips_fetch_buf.sv
// Prefetch FIFO between instruction memory and decode; flush outranks push and pop.
module mips_fetch_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads, prefetch buffer to decode.
// Optional MIPS_FETCH_PERF_EN adds saturating fetched/stall performance counters.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(32'h0000_0000),
  parameter int unsigned        BUF_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_word,
  output logic [ADDR_W-1:0] inst_pc
`ifdef MIPS_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned ENT_W = INST_W + ADDR_W;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_e      state;
  fetch_state_e      state_n;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] req_pc_n;
  logic              req_n;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_n;
  logic              grant;
  logic              push;
  logic              pop;
  logic              buf_full;
  logic              buf_empty;
  logic [ADDR_W-1:0] redirect_target;
  logic [ENT_W-1:0]  head;

  assign grant           = imem_req && imem_gnt;
  assign redirect_target = redirect_pc & ALIGN_MASK;
  assign push            = (state == WAIT) && imem_rvalid && !redirect_valid && (!buf_full || pop);
  assign pop             = !buf_empty && inst_ready && !redirect_valid;

  always_comb begin
    count_n = count + CNT_W'(push) - CNT_W'(pop);
    if (redirect_valid) count_n = '0;
  end

  // Next state, PC and the request that will be presented next cycle.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    req_pc_n = req_pc;
    req_n    = 1'b0;
    unique case (state)
      FETCH: begin
        if (grant) begin
          state_n  = WAIT;
          req_pc_n = pc;
          pc_n     = pc + ADDR_W'(PC_STEP);
        end
      end
      WAIT:    if (imem_rvalid) state_n = FETCH;
      DROP:    if (imem_rvalid) state_n = FETCH;
      default: state_n = FETCH;
    endcase
    // A response landing in the redirect cycle leaves nothing in flight to drop.
    if (redirect_valid) begin
      pc_n = redirect_target;
      if (grant || ((state != FETCH) && !imem_rvalid)) state_n = DROP;
      else                                             state_n = FETCH;
    end
    req_n = (state_n == FETCH) && (count_n < CNT_W'(BUF_DEPTH));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      pc        <= RESET_PC & ALIGN_MASK;
      req_pc    <= '0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC & ALIGN_MASK;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_pc    <= req_pc_n;
      imem_req  <= req_n;
      imem_addr <= pc_n;
    end
  end

  mips_fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENT_W)
  ) u_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wdata   ({imem_rdata, req_pc}),
    .rdata   (head),
    .full    (buf_full),
    .empty   (buf_empty),
    .count   (count)
  );

  assign inst_valid = !buf_empty;
  assign inst_word  = buf_empty ? NOP_WORD : head[ENT_W-1:ADDR_W];
  assign inst_pc    = buf_empty ? '0 : head[ADDR_W-1:0];

`ifdef MIPS_FETCH_PERF_EN
  // Saturating counters; only reset clears them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if (buf_empty && !redirect_valid && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed self-checking bench for mips_fetch_unit with a one-outstanding memory responder.
module tb_mips_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks;
  int errors;

  logic [31:0] got_pc[$];
  logic [31:0] got_word[$];
  logic [31:0] gnt_log[$];

  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] gnt_addr;
  logic        hold_en;
  logic [31:0] hold_addr;

  mips_fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_pc        (inst_pc)
`ifdef MIPS_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h2109_0003;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [31:0] pc_at(input int i);
    if (i < got_pc.size()) return got_pc[i];
    return 'x;
  endfunction

  function automatic logic [31:0] word_out(input int i);
    if (i < got_word.size()) return got_word[i];
    return 'x;
  endfunction

  // Memory: grants a live request unless one is outstanding, answers one cycle later.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend        = 1'b0;
    pend_addr   = '0;
    gnt_addr    = '0;
    forever begin
      @(negedge clock);
      imem_rvalid = 1'b0;
      if (imem_gnt) begin
        pend      = 1'b1;
        pend_addr = gnt_addr;
        gnt_log.push_back(gnt_addr);
      end
      if (pend && !(hold_en && (pend_addr == hold_addr))) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(pend_addr);
        pend        = 1'b0;
      end
      imem_gnt = imem_req && !pend;
      gnt_addr = imem_addr;
    end
  end

  // Decode-side record of every instruction actually consumed.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && inst_valid && inst_ready && !redirect_valid) begin
        got_pc.push_back(inst_pc);
        got_word.push_back(inst_word);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    tick();
    reset_n        = 1'b0;
    inst_ready     = rdy;
    redirect_valid = 1'b0;
    hold_en        = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_got(input int target, output bit ok);
    int n = 0;
    while ((got_pc.size() < target) && (n < 300)) begin
      tick();
      n++;
    end
    ok = (got_pc.size() >= target);
  endtask

  task automatic wait_gnt(input int from, input logic [31:0] addr, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && (n < 300)) begin
      for (int i = from; i < gnt_log.size(); i++) if (gnt_log[i] == addr) ok = 1'b1;
      if (!ok) begin
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    checks++; if (inst_word !== 32'h0) begin errors++; $display("FAIL reset_word got %h exp 0", inst_word); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", inst_pc); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int base;
    int gb;
    bit ok;
    do_reset(1'b1);
    base = got_pc.size();
    gb   = gnt_log.size();
    wait_got(base + 2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got %0d exp %0d", got_pc.size() - base, 2); end
    checks++; if (pc_at(base) !== 32'h0) begin errors++; $display("FAIL basic_pc0 got %h exp 00000000", pc_at(base)); end
    checks++; if (word_out(base) !== 32'h2008_0005) begin errors++; $display("FAIL basic_word0 got %h exp 20080005", word_out(base)); end
    checks++; if (pc_at(base + 1) !== 32'h4) begin errors++; $display("FAIL basic_pc1 got %h exp 00000004", pc_at(base + 1)); end
    checks++; if (word_out(base + 1) !== 32'h2109_0003) begin errors++; $display("FAIL basic_word1 got %h exp 21090003", word_out(base + 1)); end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = (gb + i < gnt_log.size()) ? gnt_log[gb + i] : 'x;
      checks++; if (a !== 32'(i * 4)) begin errors++; $display("FAIL basic_addr%0d got %h exp %h", i, a, 32'(i * 4)); end
    end
  endtask

  task automatic test_backpressure();
    int base;
    int gb;
    bit ok;
    do_reset(1'b0);
    gb = gnt_log.size();
    repeat (20) tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req got %b exp 0", imem_req); end
    checks++; if (gnt_log.size() - gb != 4) begin errors++; $display("FAIL bp_fetches got %0d exp 4", gnt_log.size() - gb); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head got %b/%h exp 1/00000000", inst_valid, inst_pc); end
    base = got_pc.size();
    inst_ready = 1'b1;
    wait_got(base + 4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got %0d exp 4", got_pc.size() - base); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc_at(base + i) !== 32'(i * 4)) begin errors++; $display("FAIL bp_pc%0d got %h exp %h", i, pc_at(base + i), 32'(i * 4)); end
      checks++; if (word_out(base + i) !== word_at(32'(i * 4))) begin errors++; $display("FAIL bp_word%0d got %h exp %h", i, word_out(base + i), word_at(32'(i * 4))); end
    end
  endtask

  task automatic test_redirect_drop();
    int base;
    int gb;
    bit ok;
    do_reset(1'b1);
    hold_en   = 1'b1;
    hold_addr = 32'h8;
    base = got_pc.size();
    gb   = gnt_log.size();
    wait_gnt(gb, 32'h8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_gnt_timeout got none exp grant at 00000008"); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    hold_en        = 1'b0;
    wait_got(base + 3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_timeout got %0d exp 3", got_pc.size() - base); end
    checks++; if (pc_at(base) !== 32'h0 || pc_at(base + 1) !== 32'h4) begin errors++; $display("FAIL drop_prefix got %h,%h exp 00000000,00000004", pc_at(base), pc_at(base + 1)); end
    checks++; if (pc_at(base + 2) !== 32'h40) begin errors++; $display("FAIL drop_pc got %h exp 00000040", pc_at(base + 2)); end
    checks++; if (word_out(base + 2) !== word_at(32'h40)) begin errors++; $display("FAIL drop_word got %h exp %h", word_out(base + 2), word_at(32'h40)); end
  endtask

  task automatic test_redirect_pop();
    int base;
    int gb;
    bit ok;
    do_reset(1'b0);
    hold_en   = 1'b1;
    hold_addr = 32'hC;
    gb = gnt_log.size();
    wait_gnt(gb, 32'hC, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rp_gnt_timeout got none exp grant at 0000000c"); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL rp_head got %b/%h exp 1/00000000", inst_valid, inst_pc); end
    base           = got_pc.size();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rp_valid got %b exp 0", inst_valid); end
    hold_en = 1'b0;
    wait_got(base + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rp_timeout got %0d exp 1", got_pc.size() - base); end
    checks++; if (pc_at(base) !== 32'h80) begin errors++; $display("FAIL rp_pc got %h exp 00000080", pc_at(base)); end
  endtask

  task automatic test_wrap();
    int base;
    int n;
    bit ok;
    do_reset(1'b1);
    tick();
    base           = got_pc.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_got(base + 2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got %0d exp 2", got_pc.size() - base); end
    checks++; if (pc_at(base) !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got %h exp fffffffc", pc_at(base)); end
    checks++; if (word_out(base) !== 32'hA5A5_FFFC) begin errors++; $display("FAIL wrap_word0 got %h exp a5a5fffc", word_out(base)); end
    checks++; if (pc_at(base + 1) !== 32'h0) begin errors++; $display("FAIL wrap_pc1 got %h exp 00000000", pc_at(base + 1)); end
    base           = got_pc.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (!imem_req && n < 50) begin
      tick();
      n++;
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL align_addr got %b/%h exp 1/00000040", imem_req, imem_addr); end
    wait_got(base + 1, ok);
    checks++; if (pc_at(base) !== 32'h40) begin errors++; $display("FAIL align_pc got %h exp 00000040", pc_at(base)); end
  endtask

  task automatic test_reset_midreq();
    int base;
    int gb;
    int n;
    bit ok;
    do_reset(1'b0);
    hold_en   = 1'b1;
    hold_addr = 32'h4;
    gb = gnt_log.size();
    wait_gnt(gb, 32'h4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mr_gnt_timeout got none exp grant at 00000004"); end
    checks++; if (inst_valid !== 1'b1 || inst_word !== 32'h2008_0005) begin errors++; $display("FAIL mr_pre got %b/%h exp 1/20080005", inst_valid, inst_word); end
    reset_n = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b exp 0", inst_valid); end
    checks++; if (inst_word !== 32'h0) begin errors++; $display("FAIL mr_word got %h exp 0", inst_word); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mr_req got %b exp 0", imem_req); end
    tick();
    tick();
    reset_n    = 1'b1;
    inst_ready = 1'b1;
    base       = got_pc.size();
    n = 0;
    while (!imem_req && n < 50) begin
      tick();
      n++;
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mr_addr got %b/%h exp 1/00000000", imem_req, imem_addr); end
    hold_en = 1'b0;
    wait_got(base + 2, ok);
    checks++; if (pc_at(base) !== 32'h0 || word_out(base) !== 32'h2008_0005) begin errors++; $display("FAIL mr_first got %h/%h exp 00000000/20080005", pc_at(base), word_out(base)); end
    checks++; if (pc_at(base + 1) !== 32'h4 || word_out(base + 1) !== 32'h2109_0003) begin errors++; $display("FAIL mr_second got %h/%h exp 00000004/21090003", pc_at(base + 1), word_out(base + 1)); end
`ifdef MIPS_FETCH_PERF_EN
    checks++; if (perf_fetched == 32'h0) begin errors++; $display("FAIL perf_count got %h exp nonzero", perf_fetched); end
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin errors++; $display("FAIL perf_reset got %h/%h exp 0/0", perf_fetched, perf_stall); end
    tick();
    reset_n = 1'b1;
`endif
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    hold_en        = 1'b0;
    hold_addr      = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_drop();
    test_redirect_pop();
    test_wrap();
    test_reset_midreq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of mips_core's decode logic.
- Owns the program counter and issues word reads to instruction memory.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffer and discarding any in-flight response.

Parameters:
- ADDR_W, 32, PC and memory address width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 4, prefetch FIFO depth; power of two, minimum 2.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- imem_req  out  1  read request, held until accepted.
- imem_addr  out  ADDR_W  byte address of the request; always word aligned.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  ADDR_W  redirect target.
- inst_valid  out  1  buffer head is valid.
- inst_ready  in  1  decode consumes the head.
- inst_word  out  32  instruction at the buffer head.
- inst_pc  out  ADDR_W  PC of inst_word.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; buffer empty; state=FETCH.
  - imem_req=0, inst_valid=0, inst_word=0, inst_pc=0.
- At most one outstanding memory request.
- FSM FETCH:
  - Assert imem_req with imem_addr=pc when the buffer has a free slot (count<BUF_DEPTH).
  - On imem_gnt: record req_pc=pc; pc<=pc+4 (wraps modulo 2^ADDR_W); go to WAIT.
- FSM WAIT:
  - On imem_rvalid: push {imem_rdata, req_pc}; go to FETCH.
  - A new request may be issued in the same cycle if a slot remains after the push.
- FSM DROP:
  - Entered on a redirect while a request is in flight.
  - On imem_rvalid: discard the data; go to FETCH.
  - No new request is issued while in DROP.
- imem_req and imem_addr stay stable until imem_gnt. A redirect in FETCH with req high and no grant withdraws the request and updates the address on the next cycle.
- Redirect, in any state:
  - Buffer flushed next cycle; pc<=redirect_pc.
  - WAIT, or FETCH with grant in the same cycle → DROP.
  - Otherwise → FETCH.
  - A redirect outranks a simultaneous push and a simultaneous pop: the pop does not count as a consumption, and inst_valid=0 the cycle after.
  - Lower 2 bits of redirect_pc are forced to 0.
- Handshake: head pops when inst_valid && inst_ready. inst_word/inst_pc stay stable while inst_valid && !inst_ready.
- Full buffer: no new request is issued. Because at most one request is outstanding and the slot is checked at issue, no response is ever dropped except in DROP.
- Simultaneous push and pop on a full buffer is legal; count is unchanged.
- Empty buffer: a push appears on inst_valid the next cycle. Zero-latency bypass is not required.
- Reset asserted mid-request: all state clears immediately. The first imem_rvalid after reset release while in FETCH is ignored.

Optional Feature:
- Macro: MIPS_FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] (count of instructions popped to decode) and perf_stall[31:0] (cycles with inst_valid=0 && !redirect_valid).
  - Both are saturating, cleared by reset_n and by redirect? No: redirects do not clear them.
- Undefined: neither port nor the counter logic exists.

Decomposition:
- Package mips_pkg holds:
  - fetch state enum {FETCH, WAIT, DROP};
  - INST_W=32;
  - PC_STEP=4;
  - NOP_WORD=32'h0000_0000.
- Sub-module mips_fetch_buf: synchronous FIFO, BUF_DEPTH x (32+ADDR_W).
  - Ports: push, pop, flush, full, empty, count.
  - Flush has priority over push and pop.

Test Plan:
- Reset with inst_ready=1, memory grants immediately with 1-cycle rvalid; words 0x20080005, 0x21090003 at 0x0, 0x4 → decode receives them in order with inst_pc 0x0, 0x4; imem_addr steps 0x0, 0x4, 0x8.
- inst_ready=0 for 20 cycles → exactly BUF_DEPTH=4 words buffered; imem_req deasserts; on release, words 0x0..0xC drain in order with no loss.
- Redirect to 0x40 while in WAIT for 0x8 → the response for 0x8 is discarded; the next inst_pc is 0x40; no instruction from 0x8 reaches decode.
- Redirect and pop in the same cycle with 3 words buffered → inst_valid=0 next cycle; the first valid output afterwards has inst_pc=redirect_pc.
- redirect_pc=0xFFFF_FFFC → fetches 0xFFFF_FFFC, then wraps to 0x0000_0000; redirect_pc=0x43 → imem_addr=0x40.
- reset_n pulsed low while a request is outstanding → outputs clear asynchronously; after release imem_addr=RESET_PC; a stale imem_rvalid is ignored. With MIPS_FETCH_PERF_EN defined, perf_fetched=0 after reset.
